// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor control blocks (regulator, PWM, frequency detector).
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package motor_ctrl_pkg;

    // Regulator FSM encoding, also exported on the state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2
    } state_e;

    // Largest unsigned duty word representable in a given width.
    function automatic int duty_max_of(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int DUTY_WIDTH_DEFAULT = 15;
    localparam int DUTY_MAX_DEFAULT   = duty_max_of(DUTY_WIDTH_DEFAULT);

    // Saturate a signed value into [lo, hi].
    function automatic logic signed [31:0] sat_clamp(
        input logic signed [31:0] val,
        input logic signed [31:0] lo,
        input logic signed [31:0] hi
    );
        if (val < lo) begin
            return lo;
        end else if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

endpackage

// File: rtl/update_tick_gen.sv
// Free-running divider producing a single-cycle tick every CLK_FREQ_HZ/UPDATE_HZ clocks.
// Latency: tick is high during the cycle the count equals TICK_DIV-1; first tick TICK_DIV cycles after reset.
// Backpressure: none, the tick cannot be stalled.
module update_tick_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int UPDATE_HZ   = 100
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int TICK_DIV = CLK_FREQ_HZ / UPDATE_HZ;
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero after the terminal value.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Divider register; reset restarts the tick phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/motor_speed_regulator.sv
// PI speed regulator with brake-and-reverse sequencing ahead of the DC motor controller.
// Latency: outputs register one cycle after an update tick; enable low forces IDLE on the next edge.
// Backpressure: none, inputs are sampled level-wise on each tick.
module motor_speed_regulator
    import motor_ctrl_pkg::*;
#(
    parameter int FREQ_WIDTH   = 8,
    parameter int DUTY_WIDTH   = 15,
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int UPDATE_HZ    = 100,
    parameter int KP_SHIFT     = 4,
    parameter int KI_SHIFT     = 2,
    parameter int STOP_TICKS   = 3,
    parameter int AT_SPEED_TOL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [FREQ_WIDTH-1:0] target_freq,
    input  logic                  target_dir,
    input  logic [FREQ_WIDTH-1:0] meas_freq,
    output logic [DUTY_WIDTH-1:0] duty,
    output logic                  dir_out,
    output logic [1:0]            state,
    output logic                  at_speed
);

    localparam int DUTY_MAX = duty_max_of(DUTY_WIDTH);
    localparam int IW       = DUTY_WIDTH + 2;
    localparam int SCW      = $clog2(STOP_TICKS + 1);
    localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_TICKS - 1);

    logic tick;

    update_tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .UPDATE_HZ   (UPDATE_HZ)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    state_e                 state_q, state_d;
    logic [DUTY_WIDTH-1:0]  duty_q, duty_d;
    logic signed [IW-1:0]   integ_q, integ_d;
    logic                   dir_q, dir_d;
    logic                   at_speed_q, at_speed_d;
    logic [SCW-1:0]         stop_cnt_q, stop_cnt_d;

    // PI arithmetic runs at 32 bits so nothing wraps before the clamp.
    logic signed [FREQ_WIDTH:0] err;
    logic signed [31:0]         err_w, err_abs, integ_w;
    logic signed [31:0]         integ_new, duty_new;
    logic                       in_tol;
    logic                       unused_hi_bits;

    // Error, integrator and duty candidates for the current tick.
    always_comb begin
        err       = $signed({1'b0, target_freq}) - $signed({1'b0, meas_freq});
        err_w     = {{(32-FREQ_WIDTH-1){err[FREQ_WIDTH]}}, err};
        err_abs   = (err_w < 0) ? -err_w : err_w;
        in_tol    = (err_abs <= AT_SPEED_TOL);
        integ_w   = {{(32-IW){integ_q[IW-1]}}, integ_q};
        integ_new = sat_clamp(integ_w + (err_w <<< KI_SHIFT), 0, DUTY_MAX);
        duty_new  = sat_clamp(integ_new + (err_w <<< KP_SHIFT), 0, DUTY_MAX);
    end

    assign unused_hi_bits = ^{integ_new[31:IW], duty_new[31:DUTY_WIDTH]};

    // FSM and loop state update; enable low overrides everything, including a coincident tick.
    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        integ_d    = integ_q;
        dir_d      = dir_q;
        at_speed_d = at_speed_q;
        stop_cnt_d = stop_cnt_q;
        if (!enable) begin
            state_d    = ST_IDLE;
            duty_d     = '0;
            integ_d    = '0;
            at_speed_d = 1'b0;
            stop_cnt_d = '0;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    duty_d     = '0;
                    integ_d    = '0;
                    stop_cnt_d = '0;
                    state_d    = (target_dir == dir_q) ? ST_RUN : ST_BRAKE;
                end
                ST_RUN: begin
                    if (target_dir != dir_q) begin
                        state_d    = ST_BRAKE;
                        duty_d     = '0;
                        integ_d    = '0;
                        stop_cnt_d = '0;
                    end else begin
                        integ_d = integ_new[IW-1:0];
                        duty_d  = duty_new[DUTY_WIDTH-1:0];
                    end
                end
                ST_BRAKE: begin
                    duty_d  = '0;
                    integ_d = '0;
                    if (target_dir == dir_q) begin
                        // Reversal withdrawn: resume without touching dir_out.
                        state_d    = ST_RUN;
                        stop_cnt_d = '0;
                    end else if (meas_freq == '0) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            // Shaft confirmed stopped: safe to flip direction.
                            dir_d      = target_dir;
                            stop_cnt_d = '0;
                            state_d    = ST_RUN;
                        end else begin
                            stop_cnt_d = stop_cnt_q + SCW'(1);
                        end
                    end else begin
                        stop_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    duty_d     = '0;
                    integ_d    = '0;
                    stop_cnt_d = '0;
                end
            endcase
            at_speed_d = (state_d == ST_RUN) && in_tol;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            integ_q    <= '0;
            dir_q      <= 1'b0;
            at_speed_q <= 1'b0;
            stop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            integ_q    <= integ_d;
            dir_q      <= dir_d;
            at_speed_q <= at_speed_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    assign duty     = duty_q;
    assign dir_out  = dir_q;
    assign state    = state_q;
    assign at_speed = at_speed_q;

endmodule

// File: tb/tb_motor_speed_regulator.sv
// Directed bench for motor_speed_regulator with a queued scoreboard and a negedge monitor.
// Latency: expectations are tagged with the cycle at which the registered outputs must hold them.
// Backpressure: none, the monitor samples every cycle that has a due expectation.
module tb_motor_speed_regulator;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  target_freq;
    logic        target_dir;
    logic [7:0]  meas_freq;
    logic [14:0] duty;
    logic        dir_out;
    logic [1:0]  state;
    logic        at_speed;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tc       = 0;

    typedef struct {
        int    due;
        string name;
        int    duty;
        int    dir;
        int    st;
        int    at;
    } exp_t;

    exp_t q[$];

    motor_speed_regulator #(
        .CLK_FREQ_HZ (1000),
        .UPDATE_HZ   (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .target_freq (target_freq),
        .target_dir  (target_dir),
        .meas_freq   (meas_freq),
        .duty        (duty),
        .dir_out     (dir_out),
        .state       (state),
        .at_speed    (at_speed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count and tick-phase model (tick every 10 clocks, phase restarts on reset).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) tc <= 0;
        else       tc <= (tc == 9) ? 0 : tc + 1;
    end

    task automatic cmp(input string nm, input string fld, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp_v);
        end
    endtask

    task automatic expect_at(input int due, input string nm, input int d, input int dr,
                             input int st, input int at);
        exp_t e;
        e.due  = due;
        e.name = nm;
        e.duty = d;
        e.dir  = dr;
        e.st   = st;
        e.at   = at;
        q.push_back(e);
    endtask

    // Expect values right after the next tick edge, then advance to it.
    task automatic tick_chk(input string nm, input int d, input int dr, input int st, input int at);
        int n;
        n = 10 - tc;
        expect_at(cyc + n, nm, d, dr, st, at);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect values after the very next edge, then advance to it.
    task automatic cyc_chk(input string nm, input int d, input int dr, input int st, input int at);
        expect_at(cyc + 1, nm, d, dr, st, at);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that falls due on this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                if (e.due < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s: sample slot %0d missed at cycle %0d", e.name, e.due, cyc);
                end else begin
                    cmp(e.name, "duty", int'(duty), e.duty);
                    cmp(e.name, "dir_out", int'(dir_out), e.dir);
                    cmp(e.name, "state", int'(state), e.st);
                    cmp(e.name, "at_speed", int'(at_speed), e.at);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_d;
        int integ_m;
        reset       = 1'b1;
        enable      = 1'b0;
        target_freq = 8'd0;
        target_dir  = 1'b0;
        meas_freq   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        expect_at(cyc, "reset", 0, 0, 0, 0);
        reset = 1'b0;

        // Start-up: IDLE -> RUN on first tick, PI on second.
        enable      = 1'b1;
        target_freq = 8'd50;
        tick_chk("run_entry", 0, 0, 1, 0);
        tick_chk("pi_first", 1000, 0, 1, 0);

        // Clear integrator via IDLE, then saturate with full-scale error.
        enable = 1'b0;
        cyc_chk("idle_clr", 0, 0, 0, 0);
        enable      = 1'b1;
        target_freq = 8'd255;
        tick_chk("rerun", 0, 0, 1, 0);
        for (int n = 1; n <= 32; n++) begin
            exp_d = 1020 * n + 4080;
            if (exp_d > 32767) exp_d = 32767;
            tick_chk($sformatf("sat_%0d", n), exp_d, 0, 1, 0);
        end

        // at_speed tolerance boundary (integ starts at 32640).
        target_freq = 8'd100;
        meas_freq   = 8'd99;
        tick_chk("tol_err1", 32660, 0, 1, 1);
        meas_freq = 8'd95;
        tick_chk("tol_err5", 32744, 0, 1, 0);
        meas_freq = 8'd102;
        tick_chk("tol_errm2", 32624, 0, 1, 1);
        meas_freq = 8'd97;
        tick_chk("tol_err3", 32716, 0, 1, 0);

        // Zero target: unwind to floor with no state change (integ starts at 32668).
        target_freq = 8'd0;
        meas_freq   = 8'd255;
        for (int k = 1; k <= 34; k++) begin
            integ_m = 32668 - 1020 * k;
            if (integ_m < 0) integ_m = 0;
            exp_d = integ_m - 4080;
            if (exp_d < 0) exp_d = 0;
            tick_chk($sformatf("floor_%0d", k), exp_d, 0, 1, 0);
        end
        target_freq = 8'd60;
        meas_freq   = 8'd40;
        tick_chk("from_floor", 400, 0, 1, 0);

        // Reverse request: brake, interrupted stop count, then flip.
        target_dir = 1'b1;
        tick_chk("brake_entry", 0, 0, 2, 0);
        meas_freq = 8'd0;
        tick_chk("stop_1", 0, 0, 2, 0);
        tick_chk("stop_2", 0, 0, 2, 0);
        meas_freq = 8'd7;
        tick_chk("stop_broken", 0, 0, 2, 0);
        meas_freq = 8'd0;
        tick_chk("restop_1", 0, 0, 2, 0);
        tick_chk("restop_2", 0, 0, 2, 0);
        tick_chk("dir_flip", 0, 1, 1, 0);
        tick_chk("run_rev_pi", 1200, 1, 1, 0);

        // Enable drop in cycle 4 of the interval.
        repeat (4) @(posedge clk);
        #1;
        enable = 1'b0;
        cyc_chk("en_drop", 0, 1, 0, 0);
        enable = 1'b1;
        tick_chk("reen", 0, 1, 1, 0);
        tick_chk("reen_pi", 1200, 1, 1, 0);

        // Enable low coinciding with a tick: IDLE wins.
        while (tc != 9) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        cyc_chk("en_low_tick", 0, 1, 0, 0);
        enable = 1'b1;
        tick_chk("reen2", 0, 1, 1, 0);

        // Reset while braking.
        target_dir = 1'b0;
        tick_chk("brake2", 0, 1, 2, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc_chk("reset_brake", 0, 0, 0, 0);
        reset      = 1'b0;
        target_dir = 1'b1;
        meas_freq  = 8'd0;
        tick_chk("r_brake", 0, 0, 2, 0);
        tick_chk("r_cnt1", 0, 0, 2, 0);
        target_dir = 1'b0;
        tick_chk("r_return", 0, 0, 1, 0);
        target_dir = 1'b1;
        tick_chk("r_brake3", 0, 0, 2, 0);
        tick_chk("r_c1", 0, 0, 2, 0);
        tick_chk("r_c2", 0, 0, 2, 0);
        tick_chk("r_flip", 0, 1, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
